lfsr_arb: RTL
=============

LFSR_ARB -- requirements
Module: lfsr_arb

Interface
REQ-001 Parameter: SEED, default 4'hE, reset and fallback value of the internal LFSR; SHALL be non-zero.
REQ-002 Parameter: N_REQ, default 3, number of requesters; legal range 2..4.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester request for one random sample, level, held until granted.
REQ-006 lock  input  N_REQ  per-requester burst-hold request; functional only with ARB_LOCK_EN.
REQ-007 seed_we  input  1  one-cycle pulse: load seed_i into the LFSR.
REQ-008 seed_i  input  4  seed value.
REQ-009 gnt  output  N_REQ  registered one-hot grant, at most one bit high per cycle.
REQ-010 rnd_o  output  4  registered sample, valid only while rnd_vld=1.
REQ-011 rnd_vld  output  1  registered; high exactly when any gnt bit is high.

Function
REQ-012 Internal 4-bit Fibonacci LFSR q SHALL step as q_next = {q[2:0], q[3]^q[2]}; period 15 for any non-zero state.
REQ-013 LFSR SHALL advance only on an edge that issues a grant; otherwise it holds.
REQ-014 On a granting edge: gnt[i], rnd_vld <= 1, rnd_o <= current q, q <= q_next; the sample is the pre-advance value.
REQ-015 Arbitration SHALL be combinational on req, registered into gnt; latency req to gnt = 1 cycle.
REQ-016 Round-robin: search starts at index (last_granted+1) mod N_REQ; after reset last_granted = N_REQ-1, so index 0 wins first.
REQ-017 Grants MAY issue on consecutive cycles; each grant is a one-cycle pulse; a requester still holding req after its grant is re-arbitrated normally.
REQ-018 No req high: gnt=0, rnd_vld=0, rnd_o holds last value, q and pointer hold.
REQ-019 seed_we=1 SHALL take priority over arbitration: that edge loads q <= seed_i, issues no grant (gnt=0, rnd_vld=0), pointer holds.
REQ-020 seed_we with seed_i=4'h0 SHALL load SEED instead, preventing LFSR lockup.
REQ-021 Bits of req/lock at index >= N_REQ do not exist; the pointer SHALL wrap from N_REQ-1 to 0.

Reset
REQ-022 reset=1 SHALL immediately force q=SEED, gnt=0, rnd_vld=0, rnd_o=4'h0, last_granted=N_REQ-1, lock counter=0.
REQ-023 Reset mid-burst SHALL abandon the burst; the first post-reset grant returns SEED.

Configuration
REQ-024 Macro ARB_LOCK_EN: when defined, if gnt[i]=1 and req[i]&lock[i] are high at the next edge, grant SHALL stay with i (new sample each cycle), bypassing round-robin.
REQ-025 With ARB_LOCK_EN, a 3-bit lock counter SHALL cap a burst at 8 consecutive grants; grant 9 is forced to round-robin excluding i unless no other req is high.
REQ-026 Without ARB_LOCK_EN, lock SHALL be ignored and no lock counter is built; behaviour is pure round-robin.

Verification
REQ-027 Reset, then req=3'b001 held 4 cycles -> gnt[0] pulses each cycle, rnd_o = E, C, 8, 1.
REQ-028 Reset, req=3'b111 held -> gnt order 0,1,2,0 on consecutive cycles, rnd_o = E, C, 8, 1.
REQ-029 seed_we=1, seed_i=4'h1 with req=3'b010 same cycle -> no grant that cycle; next cycle gnt[1], rnd_o=1, then 2, 4, 9.
REQ-030 seed_we=1, seed_i=4'h0 -> q=SEED; next grant returns E.
REQ-031 ARB_LOCK_EN, req=3'b011, lock=3'b001 held -> gnt[0] for 8 cycles, gnt[1] on cycle 9; without macro -> alternating 0,1.
REQ-032 Assert reset during a granted cycle -> gnt=0 and rnd_vld=0 before next edge; first post-reset grant rnd_o=E to index 0.

Source files
------------

// File: rtl/lfsr_arb.sv
// ---------------------------------------------------------------------------
// lfsr_arb -- round-robin arbiter that hands out pseudo-random 4-bit samples.
//
// A 4-bit Fibonacci LFSR (taps q[3]^q[2], period 15) supplies the samples.
// Each edge that issues a grant does three things:
//   - pulses one gnt bit
//   - presents the pre-advance LFSR value on rnd_o
//   - steps the LFSR
// The LFSR holds on every other edge.
//
// Parameters
//   SEED   : reset / fallback LFSR value, must be non-zero (default 4'hE)
//   N_REQ  : number of requesters, 2..4 (default 3)
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   req      in   [N_REQ] level requests, held until granted
//   lock     in   [N_REQ] burst-hold requests (only with ARB_LOCK_EN)
//   seed_we  in   one-cycle pulse: load seed_i (0 loads SEED); no grant that edge
//   seed_i   in   [4] seed value
//   gnt      out  [N_REQ] registered one-hot grant pulse
//   rnd_o    out  [4] registered sample, valid while rnd_vld is high
//   rnd_vld  out  registered, high exactly when a gnt bit is high
//
// Optional feature (macro ARB_LOCK_EN)
//   When this macro is defined, a requester that was granted on the previous
//   cycle keeps the grant while its req and lock are both high. A 3-bit
//   counter caps such a burst at 8 consecutive grants.
//   When the macro is undefined, lock is ignored and no counter is built.
// ---------------------------------------------------------------------------
module lfsr_arb #(
  parameter logic [3:0] SEED  = 4'hE,
  parameter int         N_REQ = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  input  logic             seed_we,
  input  logic [3:0]       seed_i,
  output logic [N_REQ-1:0] gnt,
  output logic [3:0]       rnd_o,
  output logic             rnd_vld
);

  // Next value of the Fibonacci LFSR.
  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // One-hot vector with only bit 'idx' set.
  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < N_REQ; i++) begin
      v[i] = (i == int'(idx));
    end
    return v;
  endfunction

  // Registers and their next-state values.
  logic [3:0]       lfsr_q, lfsr_d;
  logic [N_REQ-1:0] gnt_q,  gnt_d;
  logic             vld_q,  vld_d;
  logic [3:0]       rnd_q,  rnd_d;
  logic [1:0]       last_q, last_d;

  // Result of the round-robin search.
  logic [1:0] rr_pick_s;
  logic       rr_found_s;

  // High when the previous holder keeps the grant (lock burst).
  logic       hold_s;

`ifdef ARB_LOCK_EN
  // The counter holds (grants so far in the current burst) - 1.
  // A value of 7 means the eighth grant has already gone out.
  logic [2:0] lock_cnt_q, lock_cnt_d;
`else
  // The lock input is intentionally ignored in the default build.
  logic lock_unused_s;
  assign lock_unused_s = ^lock;
`endif

  // Round-robin search.
  // The first pass covers the indices above last_q.
  // The second pass wraps around to 0..last_q.
  // This gives a search order of last+1, last+2, ... mod N_REQ.
  always_comb begin
    rr_pick_s  = 2'd0;
    rr_found_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rr_found_s && req[i] && (i > int'(last_q))) begin
        rr_pick_s  = 2'(i);
        rr_found_s = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!rr_found_s && req[i] && (i <= int'(last_q))) begin
        rr_pick_s  = 2'(i);
        rr_found_s = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Lock-hold decision.
  // gnt_q is one-hot on the holder and last_q names that same holder.
  // Masking gnt_q with req & lock is therefore enough to detect a hold.
  always_comb begin
`ifdef ARB_LOCK_EN
    hold_s = (|(gnt_q & req & lock)) && (lock_cnt_q != 3'd7);
`else
    hold_s = 1'b0;
`endif
  end

  // Next-state logic: seed load takes priority, then lock hold, then
  // round-robin. An edge that issues no grant leaves the LFSR, the sample
  // and the pointer unchanged.
  always_comb begin
    gnt_d  = '0;
    vld_d  = 1'b0;
    rnd_d  = rnd_q;
    lfsr_d = lfsr_q;
    last_d = last_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d = 3'd0;
`endif
    if (seed_we) begin
      // A zero seed would lock the LFSR up, so it falls back to SEED.
      lfsr_d = (seed_i == 4'h0) ? SEED : seed_i;
    end else if (hold_s) begin
      gnt_d  = onehot(last_q);
      vld_d  = 1'b1;
      rnd_d  = lfsr_q;
      lfsr_d = lfsr_step(lfsr_q);
`ifdef ARB_LOCK_EN
      lock_cnt_d = lock_cnt_q + 3'd1;
`endif
    end else if (rr_found_s) begin
      gnt_d  = onehot(rr_pick_s);
      vld_d  = 1'b1;
      rnd_d  = lfsr_q;
      lfsr_d = lfsr_step(lfsr_q);
      last_d = rr_pick_s;
    end else begin
      gnt_d = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= SEED;
      gnt_q  <= '0;
      vld_q  <= 1'b0;
      rnd_q  <= 4'h0;
      last_q <= 2'(N_REQ - 1);
    end else begin
      lfsr_q <= lfsr_d;
      gnt_q  <= gnt_d;
      vld_q  <= vld_d;
      rnd_q  <= rnd_d;
      last_q <= last_d;
    end
  end

`ifdef ARB_LOCK_EN
  // Burst-length counter. Any edge that is not a lock hold clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_cnt_q <= 3'd0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

  assign gnt     = gnt_q;
  assign rnd_o   = rnd_q;
  assign rnd_vld = vld_q;

endmodule
